// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and serialises each one
// as an asynchronous UART frame (start, LSB-first data, optional parity, stop).
module fifo_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned IDX_W  = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_e;

   state_e                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  rd_q, rd_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  bit_end;
   logic                  parity_bit;
   logic [DATA_WIDTH-1:0] shift_rot;

   // Shift register rotates rather than shifts, so its XOR stays equal to the
   // word's parity for the whole frame and no separate parity flop is needed.
   always_comb begin
      bit_end    = (baud_q == BAUD_LAST);
      shift_rot  = (shift_q >> 1) | (shift_q << (DATA_WIDTH - 1));
      parity_bit = (^shift_q) ^ (PARITY_ODD != 0);
   end

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      rd_d    = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            idx_d  = '0;
            if (tx_en && !fifo_empty) begin
               state_d = S_FETCH;
               rd_d    = 1'b1;
            end
         end

         S_FETCH: state_d = S_LATCH;

         S_LATCH: begin
            shift_d = fifo_data;
            state_d = S_START;
            tx_d    = 1'b0;
            baud_d  = '0;
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               baud_d  = '0;
               idx_d   = '0;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_rot;
               if (idx_q == DATA_LAST) begin
                  idx_d = '0;
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                     tx_d    = parity_bit;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  tx_d  = shift_rot[0];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               baud_d  = '0;
               idx_d   = '0;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         S_STOP: begin
            tx_d   = 1'b1;
            done_d = (idx_q == STOP_LAST) && (baud_q == BAUD_PRE);
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign fifo_rd_en = rd_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three fifo_uart_tx configurations sharing one FIFO model;
// sel picks which instance the FIFO and the frame checker are attached to.
module tb_fifo_uart_tx;

   localparam int unsigned CPB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_en = 1'b0;
   logic [1:0] sel = 2'd0;
   logic [7:0] fifo_data = 8'h00;
   logic [2:0] fifo_empty;
   logic [2:0] rd_w, tx_w, busy_w, done_w;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int pushes = 0, pops = 0, underflow = 0, rd_cnt = 0;
   int fifo_n;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   assign fifo_n = pushes - pops;

   // Only the selected instance sees a non-empty FIFO.
   always_comb begin
      fifo_empty = '1;
      for (int i = 0; i < 3; i++) fifo_empty[i] = (sel != 2'(i)) || (fifo_n == 0);
   end

   // FIFO model: data valid the cycle after the pop request.
   always @(posedge clk) begin
      if (rd_w[sel] === 1'b1) begin
         rd_cnt <= rd_cnt + 1;
         if (fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
            pops      <= pops + 1;
         end else begin
            underflow <= underflow + 1;
         end
      end
   end

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty[0]), .fifo_rd_en(rd_w[0]),
      .fifo_data(fifo_data), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty[1]), .fifo_rd_en(rd_w[1]),
      .fifo_data(fifo_data), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty[2]), .fifo_rd_en(rd_w[2]),
      .fifo_data(fifo_data), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

   function automatic int pe_of(input logic [1:0] s);
      return (s != 2'd0) ? 1 : 0;
   endfunction

   function automatic int odd_of(input logic [1:0] s);
      return (s == 2'd2) ? 1 : 0;
   endfunction

   function automatic int sb_of(input logic [1:0] s);
      return (s == 2'd2) ? 2 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      pushes++;
   endtask

   // Waits for the pop, then samples every clk of the frame on the selected line.
   task automatic expect_frame(input string tag, input int drop_at, output int waited);
      int nb, len, unstable, done_cnt, done_at, busy_bad, rd_bad, b;
      logic [15:0] bits;
      logic [7:0]  exp_w, obs_w;
      nb = 1 + 8 + pe_of(sel) + sb_of(sel);
      len = CPB * nb;
      unstable = 0; done_cnt = 0; done_at = 0; busy_bad = 0; rd_bad = 0;
      bits = '0;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (rd_w[sel] !== 1'b1 && waited < 400);
      if (rd_w[sel] !== 1'b1) begin
         check({tag, "_rd_timeout"}, 32'd0, 32'd1);
         return;
      end
      if (exp_q.size() == 0) begin
         check({tag, "_unexpected_frame"}, 32'd1, 32'd0);
         return;
      end
      exp_w = exp_q.pop_front();
      @(negedge clk);
      check({tag, "_latch_tx"}, 32'(tx_w[sel]), 32'd1);
      check({tag, "_rd_single"}, 32'(rd_w[sel]), 32'd0);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         if (k == drop_at) tx_en = 1'b0;
         b = k / CPB;
         if (k % CPB == 0) bits[b] = tx_w[sel];
         else if (tx_w[sel] !== bits[b]) unstable++;
         if (done_w[sel] === 1'b1) begin
            done_cnt++;
            done_at = k + 1;
         end
         if (busy_w[sel] !== 1'b1) busy_bad++;
         if (rd_w[sel] !== 1'b0) rd_bad++;
      end
      obs_w = bits[8:1];
      check({tag, "_start"}, 32'(bits[0]), 32'd0);
      check({tag, "_data"}, 32'(obs_w), 32'(exp_w));
      if (pe_of(sel) != 0)
         check({tag, "_parity"}, 32'(bits[9]), 32'((^exp_w) ^ (odd_of(sel) != 0)));
      for (int s = 0; s < sb_of(sel); s++)
         check($sformatf("%s_stop%0d", tag, s), 32'(bits[nb - 1 - s]), 32'd1);
      check({tag, "_bit_stable"}, 32'(unstable), 32'd0);
      check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_cycle"}, 32'(done_at), 32'(len));
      check({tag, "_busy_in_frame"}, 32'(busy_bad), 32'd0);
      check({tag, "_no_rd_in_frame"}, 32'(rd_bad), 32'd0);
   endtask

   initial begin
      int w, rd0, bad, dones;

      // Reset held with an empty FIFO.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset_c%0d_tx_busy_rd", i), 32'({tx_w[0], busy_w[0], rd_w[0]}), 32'b100);
      end
      reset = 1'b0;
      tx_en = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rd_w[0] !== 1'b0) bad++;
      end
      check("idle_empty_quiet", 32'(bad), 32'd0);
      check("idle_empty_no_fetch", 32'(rd_cnt), 32'd0);

      // Single byte, no parity, one stop bit: 40-cycle frame.
      rd0 = rd_cnt;
      push(8'hA5);
      expect_frame("single_a5", -1, w);
      @(negedge clk);
      check("single_busy_after", 32'(busy_w[0]), 32'd0);
      check("single_tx_after", 32'(tx_w[0]), 32'd1);
      check("single_rd_pulses", 32'(rd_cnt - rd0), 32'd1);

      // Even parity (44 cycles) then odd parity with two stop bits (48 cycles).
      sel = 2'd1;
      push(8'hA5);
      expect_frame("par_even_a5", -1, w);
      repeat (3) @(negedge clk);
      sel = 2'd2;
      push(8'hA5);
      expect_frame("par_odd_a5", -1, w);
      repeat (3) @(negedge clk);

      // Back-to-back frames with a 3-cycle gap.
      sel = 2'd0;
      rd0 = rd_cnt;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      expect_frame("b2b_00", -1, w);
      expect_frame("b2b_ff", -1, w);
      check("b2b_gap1", 32'(w + 1), 32'd3);
      expect_frame("b2b_3c", -1, w);
      check("b2b_gap2", 32'(w + 1), 32'd3);
      @(negedge clk);
      check("b2b_busy_after", 32'(busy_w[0]), 32'd0);
      check("b2b_rd_pulses", 32'(rd_cnt - rd0), 32'd3);

      // tx_en dropped during the data bits of the first of two words.
      rd0 = rd_cnt;
      push(8'h81);
      push(8'h42);
      expect_frame("gate_81", CPB * 3 + 1, w);
      repeat (20) @(negedge clk);
      check("gate_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
      check("gate_fifo_left", 32'(fifo_n), 32'd1);
      check("gate_busy", 32'(busy_w[0]), 32'd0);
      tx_en = 1'b1;
      expect_frame("gate_42", -1, w);
      repeat (3) @(negedge clk);

      // Reset during data bit 3 of 0x5A (two stop bits).
      sel = 2'd2;
      push(8'h5A);
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (rd_w[2] !== 1'b1 && w < 100);
      check("rst_mid_fetch_seen", 32'(rd_w[2]), 32'd1);
      repeat (2 + CPB * 4 + 1) @(negedge clk);
      check("rst_mid_bit3_tx", 32'(tx_w[2]), 32'd1);
      check("rst_mid_busy", 32'(busy_w[2]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_outputs", 32'({tx_w[2], busy_w[2], rd_w[2], done_w[2]}), 32'b1000);
      reset = 1'b0;
      void'(exp_q.pop_front());
      dones = 0;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done_w[2] === 1'b1) dones++;
         if (busy_w[2] !== 1'b0 || tx_w[2] !== 1'b1) bad++;
      end
      check("rst_mid_no_done", 32'(dones), 32'd0);
      check("rst_mid_quiet", 32'(bad), 32'd0);
      push(8'h5A);
      expect_frame("rst_after_5a", -1, w);

      repeat (5) @(negedge clk);
      check("no_underflow", 32'(underflow), 32'd0);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
